uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver. Captures each completed byte from the receiver's data/done/err outputs, tags it with a framing-error flag, and queues it in a circular FIFO. The bus or host side drains it through a valid/ready handshake. It also keeps a sticky overflow flag and a saturating framing-error counter.

---
 rtl/uart_rx_fifo.sv | 93 +++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Each completed byte is queued
// with a framing-error tag. It also keeps a sticky overflow flag and a saturating error count.
module uart_rx_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Width-1:0]       rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output logic [Width-1:0]       outData,
  output logic                   outFrameErr,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(Depth):0] count,
  output logic                   overflow,
  input  logic                   clearOverflow,
  output logic [7:0]             errCount
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0]   FullCount = (PtrW+1)'(Depth);
  localparam logic [PtrW:0]   CntOne    = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [Width-1:0] dataMem [Depth];
  logic             tagMem  [Depth];
  logic [PtrW-1:0]  wrPtr, rdPtr;
  logic             pushPending, pendingErr;
  logic             full, pop, pushOk, drop, tagIn;

  assign full     = (count == FullCount);
  assign outValid = (count != '0);
  assign pop      = outValid && outReady;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign pushOk   = pushPending && (!full || pop);
  assign drop     = pushPending && full && !pop;
  assign tagIn    = pendingErr | rxErr;

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      dataMem[wrPtr] <= rxData;
      tagMem[wrPtr]  <= tagIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pushPending <= 1'b0;
      pendingErr  <= 1'b0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      errCount    <= '0;
    end else begin
      // Receiver loads rxData one cycle after rxDone, so the write is delayed a cycle.
      pushPending <= rxDone;
      if (pushPending)
        pendingErr <= 1'b0;
      else if (rxErr)
        pendingErr <= 1'b1;
      if (pushOk) wrPtr <= wrPtr + PtrOne;
      if (pop)    rdPtr <= rdPtr + PtrOne;
      case ({pushOk, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clearOverflow)
        overflow <= 1'b0;
      if (rxErr) errCount <= satInc(errCount);
    end
  end

  always_comb begin
    outData     = '0;
    outFrameErr = 1'b0;
    if (outValid) begin
      outData     = dataMem[rdPtr];
      outFrameErr = tagMem[rdPtr];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected {tag,byte} entries are queued at send
// time and a negedge monitor compares them whenever the DUT hands off an entry.
module tb_uart_rx_fifo;
  localparam int Depth = 8;
  localparam int Width = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [Width-1:0] rxData = '0;
  logic             rxDone = 1'b0;
  logic             rxErr = 1'b0;
  logic [Width-1:0] outData;
  logic             outFrameErr;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [3:0]       count;
  logic             overflow;
  logic             clearOverflow = 1'b0;
  logic [7:0]       errCount;

  uart_rx_fifo #(.Depth(Depth), .Width(Width)) dut (
    .clk(clk), .reset(reset), .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
    .outData(outData), .outFrameErr(outFrameErr), .outValid(outValid),
    .outReady(outReady), .count(count), .overflow(overflow),
    .clearOverflow(clearOverflow), .errCount(errCount)
  );

  always #5 clk = ~clk;

  int         nChecks = 0;
  int         nFail = 0;
  logic [8:0] sbq[$];
  logic       tbPendErr = 1'b0;
  int         maxCount = 0;
  logic       prodDone = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame completes now; the write lands at the end of the next cycle.
  task automatic sendByte(input logic [7:0] d, input logic errSame, input logic keep);
    rxData = d;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxErr  = errSame;
    if (keep) sbq.push_back({tbPendErr | errSame, d});
    tbPendErr = 1'b0;
    tick();
    rxErr = 1'b0;
  endtask

  task automatic pulseErr();
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    tbPendErr = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    outReady = 1'b1;
    for (n = 0; n < 64 && count != 0; n++) tick();
    outReady = 1'b0;
    check("drainEmpty", {28'd0, count}, 32'd0);
    check("drainSbEmpty", sbq.size(), 0);
  endtask

  // Monitor: an entry leaves at the next posedge when valid and ready are both high.
  always @(negedge clk) begin
    if (int'(count) > maxCount) maxCount = int'(count);
    if (!reset && outValid && outReady) begin
      if (sbq.size() == 0) begin
        check("unexpectedPop", {23'd0, outFrameErr, outData}, 32'h1FF);
      end else begin
        logic [8:0] exp;
        exp = sbq.pop_front();
        check("popData", {24'd0, outData}, {24'd0, exp[7:0]});
        check("popTag", {31'd0, outFrameErr}, {31'd0, exp[8]});
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rstValid", {31'd0, outValid}, 0);
    check("rstCount", {28'd0, count}, 0);
    check("rstOverflow", {31'd0, overflow}, 0);
    check("rstErrCount", {24'd0, errCount}, 0);
    check("rstOutData", {24'd0, outData}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single byte and latency
    rxData = 8'hA5;
    rxDone = 1'b1;
    sbq.push_back({1'b0, 8'hA5});
    tick();
    rxDone = 1'b0;
    check("lat1Valid", {31'd0, outValid}, 0);
    tick();
    check("lat2Valid", {31'd0, outValid}, 1);
    check("singleData", {24'd0, outData}, 32'hA5);
    check("singleTag", {31'd0, outFrameErr}, 0);
    check("singleCount", {28'd0, count}, 1);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("singlePopCount", {28'd0, count}, 0);
    check("singlePopValid", {31'd0, outValid}, 0);
    check("singlePopData", {24'd0, outData}, 0);

    // Error tagging: pending error, then same-cycle error
    pulseErr();
    sendByte(8'h3C, 1'b0, 1'b1);
    sendByte(8'h3D, 1'b0, 1'b1);
    check("errHeadTag", {31'd0, outFrameErr}, 1);
    check("errCount1", {24'd0, errCount}, 1);
    drain();
    sendByte(8'h77, 1'b1, 1'b1);
    sendByte(8'h78, 1'b0, 1'b1);
    check("errCount2", {24'd0, errCount}, 2);
    drain();

    // Fill, overflow, clear, set-wins-over-clear
    for (int i = 0; i < Depth; i++) sendByte(8'(i), 1'b0, 1'b1);
    check("fullCount", {28'd0, count}, Depth);
    check("fullNoOvf", {31'd0, overflow}, 0);
    sendByte(8'h08, 1'b0, 1'b0);
    check("ovfCount", {28'd0, count}, Depth);
    check("ovfSet", {31'd0, overflow}, 1);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("ovfCleared", {31'd0, overflow}, 0);
    rxData = 8'h09;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("ovfSetWins", {31'd0, overflow}, 1);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("ovfCleared2", {31'd0, overflow}, 0);

    // Push and pop together while full
    rxData = 8'h55;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    outReady = 1'b1;
    sbq.push_back({1'b0, 8'h55});
    tick();
    outReady = 1'b0;
    check("fullPPCount", {28'd0, count}, Depth);
    check("fullPPOvf", {31'd0, overflow}, 0);
    drain();

    // Wrap-around with random ready duty
    maxCount = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          for (int w = 0; w < 200 && int'(count) >= Depth - 1; w++) tick();
          sendByte(8'(8'h10 + i), 1'b0, 1'b1);
        end
        prodDone = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !(prodDone && sbq.size() == 0); c++) begin
          outReady = ($urandom_range(0, 3) != 0);
          tick();
        end
        outReady = 1'b0;
      end
    join
    check("wrapSbEmpty", sbq.size(), 0);
    check("wrapMaxOk", {31'd0, (maxCount <= Depth)}, 1);
    check("wrapCount", {28'd0, count}, 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) pulseErr();
    check("errSat", {24'd0, errCount}, 255);

    // Asynchronous reset with entries queued
    sendByte(8'hC1, 1'b0, 1'b1);
    sendByte(8'hC2, 1'b0, 1'b1);
    sendByte(8'hC3, 1'b0, 1'b1);
    check("preRstCount", {28'd0, count}, 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("asyncValid", {31'd0, outValid}, 0);
    check("asyncCount", {28'd0, count}, 0);
    check("asyncErrCount", {24'd0, errCount}, 0);
    check("asyncOverflow", {31'd0, overflow}, 0);
    sbq.delete();
    tbPendErr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    sendByte(8'h42, 1'b0, 1'b1);
    check("postRstTag", {31'd0, outFrameErr}, 0);
    drain();

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
